// File: rtl/ahb_pkg.sv
// Shared types and widths for the single-transfer AHB master.
package ahb_pkg;

   localparam int unsigned AHB_AW = 8;
   localparam int unsigned AHB_DW = 8;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA
   } state_t;

endpackage

// File: rtl/ahb_master_if.sv
// Command/response handshake plus AHB bus signals of the master.
interface ahb_master_if;
   import ahb_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [AHB_AW-1:0] cmd_addr;
   logic [AHB_DW-1:0] cmd_wdata;
   logic [AHB_AW-1:0] haddr;
   htrans_t           htrans;
   logic              hwrite;
   logic [AHB_DW-1:0] hwdata;
   logic              hready;
   logic              hresp;
   logic [AHB_DW-1:0] hrdata;
   logic              rsp_valid;
   logic [AHB_DW-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, hready, hresp, hrdata,
      output cmd_ready, haddr, htrans, hwrite, hwdata, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, hready, hresp, hrdata,
      input  cmd_ready, haddr, htrans, hwrite, hwdata, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/ahb_wait_timer.sv
// Counts consecutive data-phase wait states; expired flags the last allowed one.
module ahb_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic hclk,
   input  logic hreset,
   input  logic clear,
   input  logic wait_cycle,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
   assign expired = wait_cycle && (count == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge hclk) begin
      if (hreset || clear)
         count <= '0;
      else if (wait_cycle && !expired)
         count <= count + CW'(1);
   end

endmodule

// File: rtl/ahb_master.sv
// Single-transfer AHB master: IDLE -> ADDR -> DATA, registered response.
// Optional data-phase timeout enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_master
   import ahb_pkg::*;
(
   input  logic         hclk,
   input  logic         hreset,
   ahb_master_if.master bus
);

`ifdef AHB_MASTER_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYCLES = 16;
`endif

   state_t            state, state_nxt;
   logic              cap_write;
   logic [AHB_AW-1:0] cap_addr;
   logic [AHB_DW-1:0] cap_wdata;
   logic              rsp_valid_q, rsp_err_q;
   logic [AHB_DW-1:0] rsp_rdata_q;
   logic              accept, done, done_err;
   logic [AHB_DW-1:0] done_rdata;
   logic              timeout;

`ifdef AHB_MASTER_TIMEOUT_EN
   ahb_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .hclk       (hclk),
      .hreset     (hreset),
      .clear      (state == ST_ADDR && bus.hready),
      .wait_cycle (state == ST_DATA && !bus.hready),
      .expired    (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      done       = 1'b0;
      done_err   = 1'b0;
      done_rdata = '0;
      case (state)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               accept    = 1'b1;
               state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (bus.hready)
               state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (bus.hready) begin
               done       = 1'b1;
               done_err   = bus.hresp;
               done_rdata = (!cap_write && !bus.hresp) ? bus.hrdata : '0;
               state_nxt  = ST_IDLE;
            end else if (timeout) begin
               done      = 1'b1;
               done_err  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state       <= ST_IDLE;
         cap_write   <= 1'b0;
         cap_addr    <= '0;
         cap_wdata   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state       <= state_nxt;
         rsp_valid_q <= done;
         rsp_err_q   <= done_err;
         rsp_rdata_q <= done_rdata;
         if (accept) begin
            cap_write <= bus.cmd_write;
            cap_addr  <= bus.cmd_addr;
            cap_wdata <= bus.cmd_wdata;
         end
      end
   end

   assign bus.cmd_ready = (state == ST_IDLE) && !hreset;
   assign bus.htrans    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.haddr     = (state != ST_IDLE) ? cap_addr : '0;
   assign bus.hwrite    = (state != ST_IDLE) ? cap_write : 1'b0;
   assign bus.hwdata    = (state == ST_DATA && cap_write) ? cap_wdata : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule
